// File: rtl/vend_fsm_param_if.sv
// Vending FSM bus: coin acceptor and hopper/dispenser side signals.
//   coin, cancel, chg_ack      : acceptor/hopper -> FSM
//   drink, chg_valid,
//   chg_is_refund, coin_reject,
//   credit, vend_count         : FSM -> dispenser/hopper/status
// master = acceptor/hopper side, slave = the vending FSM.
interface vend_fsm_param_if #(
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 4,
  parameter int CNT_W    = 8
);
  logic [COIN_W-1:0]   coin;
  logic                cancel;
  logic                chg_ack;
  logic                drink;
  logic                chg_valid;
  logic                chg_is_refund;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic [CNT_W-1:0]    vend_count;

  modport master (
    output coin, cancel, chg_ack,
    input  drink, chg_valid, chg_is_refund, coin_reject, credit, vend_count
  );

  modport slave (
    input  coin, cancel, chg_ack,
    output drink, chg_valid, chg_is_refund, coin_reject, credit, vend_count
  );
endinterface

// File: rtl/vend_fsm_param.sv
// Parametrised coin-operated vending FSM.
// Accumulates multi-value coin credit up to PRICE, pulses drink for one
// cycle, then pays change (or a cancel refund) as unit coins over a
// chg_valid/chg_ack handshake. Keeps a saturating count of items sold.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : vend_fsm_param_if.slave (coin/cancel/chg_ack in;
//          drink/chg_valid/chg_is_refund/coin_reject/credit/vend_count out)
// All outputs are registers; no combinational input-to-output path.
module vend_fsm_param #(
  parameter int PRICE    = 4,
  parameter int COIN_W   = 2,
  parameter int CREDIT_W = 4,
  parameter int CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  vend_fsm_param_if.slave bus
);

  // Worst-case credit: PRICE-1 already held plus the largest coin.
  localparam int MAX_CREDIT = PRICE - 1 + (1 << COIN_W) - 1;

  if (PRICE < 1) begin : g_chk_price
    $error("vend_fsm_param: PRICE must be at least 1");
  end
  if (MAX_CREDIT > (1 << CREDIT_W) - 1) begin : g_chk_credit
    $error("vend_fsm_param: CREDIT_W too narrow for PRICE-1 + max coin");
  end

  typedef enum logic [2:0] {IDLE, COLLECT, VEND, CHANGE, REFUND} state_t;

  localparam logic [CREDIT_W:0]   PRICE_S = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              state;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    vend_count_q;
  logic                drink_q, chg_valid_q, chg_is_refund_q, coin_reject_q;
  logic                coin_nz;
  logic [CREDIT_W:0]   sum;

  assign coin_nz = (bus.coin != '0);
  // One extra bit so the price compare can never wrap.
  assign sum     = {1'b0, credit_q} + (CREDIT_W+1)'(bus.coin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      credit_q        <= '0;
      vend_count_q    <= '0;
      drink_q         <= 1'b0;
      chg_valid_q     <= 1'b0;
      chg_is_refund_q <= 1'b0;
      coin_reject_q   <= 1'b0;
    end else begin
      drink_q       <= 1'b0;
      coin_reject_q <= 1'b0;
      case (state)
        IDLE: begin
          // credit is 0 here, so sum is just the coin; cancel is ignored.
          if (coin_nz) begin
            credit_q <= sum[CREDIT_W-1:0];
            if (sum >= PRICE_S) begin
              state   <= VEND;
              drink_q <= 1'b1;
            end else begin
              state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (bus.cancel) begin
            // Cancel wins over a same-cycle coin, which is bounced.
            state           <= REFUND;
            chg_valid_q     <= 1'b1;
            chg_is_refund_q <= 1'b1;
            coin_reject_q   <= coin_nz;
          end else if (coin_nz) begin
            credit_q <= sum[CREDIT_W-1:0];
            if (sum >= PRICE_S) begin
              state   <= VEND;
              drink_q <= 1'b1;
            end
          end
        end
        VEND: begin
          coin_reject_q <= coin_nz;
          credit_q      <= credit_q - PRICE_C;
          if (vend_count_q != '1) vend_count_q <= vend_count_q + 1'b1;
          if (credit_q > PRICE_C) begin
            state           <= CHANGE;
            chg_valid_q     <= 1'b1;
            chg_is_refund_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        CHANGE, REFUND: begin
          coin_reject_q <= coin_nz;
          if (bus.chg_ack) begin
            credit_q <= credit_q - 1'b1;
            // Last unit paid: drop valid together with the state change.
            if (credit_q == CREDIT_W'(1)) begin
              state           <= IDLE;
              chg_valid_q     <= 1'b0;
              chg_is_refund_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.drink         = drink_q;
  assign bus.chg_valid     = chg_valid_q;
  assign bus.chg_is_refund = chg_is_refund_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.credit        = credit_q;
  assign bus.vend_count    = vend_count_q;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Self-checking bench for vend_fsm_param. Each scenario task drives a
// table of per-cycle inputs, pushes the hand-derived expected outputs for
// the following cycle into a scoreboard queue, and pops/compares them
// #1 after the clock edge. A second instance with CNT_W=2 covers
// vend_count saturation.
module tb_vend_fsm_param;

  typedef struct packed {
    logic [1:0] coin;
    logic       cancel;
    logic       ack;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic       drink;
    logic       vld;
    logic       refund;
    logic       reject;
    logic [3:0] credit;
    logic [7:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  obs_t exp_q[$];

  always #5 clk = ~clk;

  vend_fsm_param_if #(.COIN_W(2), .CREDIT_W(4), .CNT_W(8)) bus ();
  vend_fsm_param_if #(.COIN_W(2), .CREDIT_W(4), .CNT_W(2)) bus2 ();

  vend_fsm_param #(.PRICE(4), .COIN_W(2), .CREDIT_W(4), .CNT_W(8)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave));

  vend_fsm_param #(.PRICE(4), .COIN_W(2), .CREDIT_W(4), .CNT_W(2)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2.slave));

  function automatic stim_t s(input logic [1:0] coin, input logic cancel,
                              input logic ack, input logic r);
    s = '{coin: coin, cancel: cancel, ack: ack, rst: r};
  endfunction

  function automatic obs_t o(input logic d, input logic v, input logic rf,
                             input logic rj, input logic [3:0] cr,
                             input logic [7:0] cnt);
    o = '{drink: d, vld: v, refund: rf, reject: rj, credit: cr, cnt: cnt};
  endfunction

  function automatic obs_t sample1();
    sample1 = '{drink: bus.drink, vld: bus.chg_valid, refund: bus.chg_is_refund,
                reject: bus.coin_reject, credit: bus.credit, cnt: bus.vend_count};
  endfunction

  function automatic obs_t sample2();
    sample2 = '{drink: bus2.drink, vld: bus2.chg_valid, refund: bus2.chg_is_refund,
                reject: bus2.coin_reject, credit: bus2.credit,
                cnt: {6'b0, bus2.vend_count}};
  endfunction

  task automatic apply(input stim_t st);
    bus.coin    = st.coin;
    bus.cancel  = st.cancel;
    bus.chg_ack = st.ack;
    rst         = st.rst;
  endtask

  task automatic test_reset();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = '{s(0,0,0,1), s(0,0,0,1), s(0,1,1,0)};
    ex = '{o(0,0,0,0,0,0), o(0,0,0,0,0,0), o(0,0,0,0,0,0)};
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // Four unit coins: exact price, no change.
  task automatic test_exact_price();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = '{s(1,0,0,0), s(1,0,0,0), s(1,0,0,0), s(1,0,0,0), s(0,0,0,0), s(0,0,0,0)};
    ex = '{o(0,0,0,0,1,0), o(0,0,0,0,2,0), o(0,0,0,0,3,0), o(1,0,0,0,4,0),
           o(0,0,0,0,0,1), o(0,0,0,0,0,1)};
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL exact_price[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // 3+3 = 6, two units of change; ack held from the VEND cycle on
  // (ignored there), so exactly two acks are consumed.
  task automatic test_change();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    int    acks;
    acks = 0;
    st = '{s(3,0,0,0), s(3,0,0,0), s(0,0,1,0), s(0,0,1,0), s(0,0,1,0), s(0,0,1,0)};
    ex = '{o(0,0,0,0,3,1), o(1,0,0,0,6,1), o(0,1,0,0,2,2), o(0,1,0,0,1,2),
           o(0,0,0,0,0,2), o(0,0,0,0,0,2)};
    foreach (st[i]) begin
      if (bus.chg_valid && st[i].ack) acks++;
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL change[%0d] got=%h exp=%h", i, got, e);
      end
    end
    n_tests++;
    if (acks !== 2) begin
      n_fail++;
      $display("FAIL change_acks got=%0d exp=2", acks);
    end
  endtask

  // 2+1 then cancel: refund of 3, one cycle stalled without ack.
  task automatic test_refund();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = '{s(2,0,0,0), s(1,0,0,0), s(0,1,0,0), s(0,0,0,0), s(0,0,1,0),
           s(0,0,1,0), s(0,0,1,0)};
    ex = '{o(0,0,0,0,2,2), o(0,0,0,0,3,2), o(0,1,1,0,3,2), o(0,1,1,0,3,2),
           o(0,1,1,0,2,2), o(0,1,1,0,1,2), o(0,0,0,0,0,2)};
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL refund[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // Coins bounced in VEND and CHANGE; cancel+ack in CHANGE only pays out;
  // coin together with cancel in COLLECT is bounced and refunds 1.
  task automatic test_reject();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = '{s(2,0,0,0), s(3,0,0,0), s(1,0,0,0), s(2,0,0,0), s(0,1,1,0),
           s(1,0,0,0), s(3,1,0,0), s(0,0,1,0)};
    ex = '{o(0,0,0,0,2,2), o(1,0,0,0,5,2), o(0,1,0,1,1,3), o(0,1,0,1,1,3),
           o(0,0,0,0,0,3), o(0,0,0,0,1,3), o(0,1,1,1,1,3), o(0,0,0,0,0,3)};
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reject[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // Reset while in CHANGE with credit 2 drops the pending change.
  task automatic test_reset_mid_change();
    stim_t st[$];
    obs_t  ex[$];
    obs_t  got, e;
    st = '{s(3,0,0,0), s(3,0,0,0), s(0,0,0,0), s(0,0,0,1), s(0,0,1,0)};
    ex = '{o(0,0,0,0,3,3), o(1,0,0,0,6,3), o(0,1,0,0,2,4), o(0,0,0,0,0,0),
           o(0,0,0,0,0,0)};
    foreach (st[i]) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = sample1(); e = exp_q.pop_front(); n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL reset_mid[%0d] got=%h exp=%h", i, got, e);
      end
    end
  endtask

  // CNT_W=2 instance: five 2+2 purchases, count saturates at 3.
  task automatic test_saturate();
    obs_t got, e;
    logic [7:0] cnt;
    cnt = 0;
    apply(s(0,0,0,0));
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 3; c++) begin
        bus2.coin    = (c < 2) ? 2'd2 : 2'd0;
        bus2.cancel  = 1'b0;
        bus2.chg_ack = 1'b0;
        if (c == 0)      exp_q.push_back(o(0,0,0,0,2,cnt));
        else if (c == 1) exp_q.push_back(o(1,0,0,0,4,cnt));
        else begin
          if (cnt < 3) cnt++;
          exp_q.push_back(o(0,0,0,0,0,cnt));
        end
        @(posedge clk); #1;
        got = sample2(); e = exp_q.pop_front(); n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL saturate[%0d.%0d] got=%h exp=%h", p, c, got, e);
        end
      end
    end
    bus2.coin = '0;
  endtask

  initial begin
    bus.coin = '0; bus.cancel = 1'b0; bus.chg_ack = 1'b0;
    bus2.coin = '0; bus2.cancel = 1'b0; bus2.chg_ack = 1'b0;
    test_reset();
    test_exact_price();
    test_change();
    test_refund();
    test_reject();
    test_reset_mid_change();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
